// File: rtl/majority_vote_sequencer.sv
// Round-based vote collector for a 5-input majority: opens on start, accepts one
// vote per voter, closes on full response, early decision or timeout.
module majority_vote_sequencer #(
  parameter int unsigned TIMEOUT    = 16,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] vote_valid,
  input  logic [4:0] vote,
  output logic       busy,
  output logic [4:0] voted,
  output logic [2:0] ones_cnt,
  output logic       result,
  output logic       result_valid,
  output logic       timeout,
  output logic       quorum_ok
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          busy_q, busy_d;
  logic [4:0]    voted_q, voted_d;
  logic [2:0]    ones_q, ones_d;
  logic          result_q, result_d;
  logic          rv_q, rv_d;
  logic          tmo_q, tmo_d;
  logic          quorum_q, quorum_d;

  logic [4:0] accept, voted_n;
  logic [2:0] ones_n, zeros_n, count_n;
  logic       all_in, early, timer_hit;

  function automatic logic [2:0] pop5(input logic [4:0] x);
    logic [2:0] c;
    c = '0;
    for (int unsigned i = 0; i < 5; i++) c = c + {2'b00, x[i]};
    return c;
  endfunction

  always_comb begin
    accept    = vote_valid & ~voted_q;
    voted_n   = voted_q | accept;
    ones_n    = ones_q + pop5(accept & vote);
    count_n   = pop5(voted_n);
    zeros_n   = count_n - ones_n;
    all_in    = &voted_n;
    early     = EARLY_EXIT && ((ones_n >= 3'd3) || (zeros_n >= 3'd3));
    timer_hit = (timer_q == TW'(TIMEOUT - 1));

    state_d  = state_q;
    timer_d  = timer_q;
    voted_d  = voted_q;
    ones_d   = ones_q;
    result_d = result_q;
    tmo_d    = tmo_q;
    quorum_d = quorum_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_COLLECT;
          timer_d  = '0;
          voted_d  = '0;
          ones_d   = '0;
          result_d = 1'b0;
          tmo_d    = 1'b0;
          quorum_d = 1'b0;
        end
      end
      S_COLLECT: begin
        voted_d = voted_n;
        ones_d  = ones_n;
        // Close decision uses the post-acceptance values of this same edge.
        if (all_in || early || timer_hit) begin
          state_d  = S_DONE;
          result_d = (ones_n >= 3'd3);
          quorum_d = (count_n >= 3'd3);
          tmo_d    = timer_hit && !all_in && !early;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    rv_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      busy_q   <= 1'b0;
      voted_q  <= '0;
      ones_q   <= '0;
      result_q <= 1'b0;
      rv_q     <= 1'b0;
      tmo_q    <= 1'b0;
      quorum_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      busy_q   <= busy_d;
      voted_q  <= voted_d;
      ones_q   <= ones_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      tmo_q    <= tmo_d;
      quorum_q <= quorum_d;
    end
  end

  assign busy         = busy_q;
  assign voted        = voted_q;
  assign ones_cnt     = ones_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign timeout      = tmo_q;
  assign quorum_ok    = quorum_q;

endmodule

// File: tb/tb_majority_vote_sequencer.sv
// Self-checking bench: three parameterisations share one stimulus stream and are
// each compared every cycle against a round-level reference model.
module tb_majority_vote_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] vote_valid = '0;
  logic [4:0] vote = '0;

  logic       busy_o [3];
  logic [4:0] voted_o [3];
  logic [2:0] ones_o [3];
  logic       result_o [3];
  logic       rv_o [3];
  logic       tmo_o [3];
  logic       quorum_o [3];

  int checks = 0;
  int errors = 0;

  localparam int  TO_P [3] = '{16, 4, 16};
  localparam bit  EE_P [3] = '{1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  majority_vote_sequencer #(.TIMEOUT(16), .EARLY_EXIT(1'b0)) u_def (
    .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid), .vote(vote),
    .busy(busy_o[0]), .voted(voted_o[0]), .ones_cnt(ones_o[0]), .result(result_o[0]),
    .result_valid(rv_o[0]), .timeout(tmo_o[0]), .quorum_ok(quorum_o[0]));

  majority_vote_sequencer #(.TIMEOUT(4), .EARLY_EXIT(1'b0)) u_to4 (
    .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid), .vote(vote),
    .busy(busy_o[1]), .voted(voted_o[1]), .ones_cnt(ones_o[1]), .result(result_o[1]),
    .result_valid(rv_o[1]), .timeout(tmo_o[1]), .quorum_ok(quorum_o[1]));

  majority_vote_sequencer #(.TIMEOUT(16), .EARLY_EXIT(1'b1)) u_ee (
    .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid), .vote(vote),
    .busy(busy_o[2]), .voted(voted_o[2]), .ones_cnt(ones_o[2]), .result(result_o[2]),
    .result_valid(rv_o[2]), .timeout(tmo_o[2]), .quorum_ok(quorum_o[2]));

  // Round-level view: phase 0 = waiting, 1 = gathering votes, 2 = announcing.
  typedef struct {
    int       phase;
    bit [4:0] voted;
    int       ones;
    int       elapsed;
    bit       result;
    bit       tmo;
    bit       quorum;
  } model_t;

  model_t m [3];

  function automatic model_t step(model_t cur, int to, bit ee, logic r, logic s,
                                  logic [4:0] vv, logic [4:0] v);
    model_t n;
    int     cnt;
    bit     all_in, early, timed;
    n = cur;
    if (r) begin
      n = '{0, 5'd0, 0, 0, 1'b0, 1'b0, 1'b0};
    end else if (cur.phase == 0) begin
      if (s) n = '{1, 5'd0, 0, 0, 1'b0, 1'b0, 1'b0};
    end else if (cur.phase == 1) begin
      for (int i = 0; i < 5; i++) begin
        if (vv[i] && !n.voted[i]) begin
          n.voted[i] = 1'b1;
          n.ones += int'(v[i]);
        end
      end
      n.elapsed++;
      cnt    = $countones(n.voted);
      all_in = (cnt == 5);
      early  = ee && (n.ones >= 3 || (cnt - n.ones) >= 3);
      timed  = (n.elapsed == to);
      if (all_in || early || timed) begin
        n.phase  = 2;
        n.result = (n.ones >= 3);
        n.quorum = (cnt >= 3);
        n.tmo    = timed && !all_in && !early;
      end
    end else begin
      n.phase = 0;
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int k);
    check($sformatf("u%0d busy", k),         8'(busy_o[k]),   8'(m[k].phase != 0));
    check($sformatf("u%0d voted", k),        8'(voted_o[k]),  8'(m[k].voted));
    check($sformatf("u%0d ones_cnt", k),     8'(ones_o[k]),   8'(m[k].ones));
    check($sformatf("u%0d result", k),       8'(result_o[k]), 8'(m[k].result));
    check($sformatf("u%0d result_valid", k), 8'(rv_o[k]),     8'(m[k].phase == 2));
    check($sformatf("u%0d timeout", k),      8'(tmo_o[k]),    8'(m[k].tmo));
    check($sformatf("u%0d quorum_ok", k),    8'(quorum_o[k]), 8'(m[k].quorum));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) m[k] = step(m[k], TO_P[k], EE_P[k], rst, start, vote_valid, vote);
    #1;
    for (int k = 0; k < 3; k++) check_all(k);
  endtask

  task automatic wait_idle();
    start = 1'b0;
    vote_valid = '0;
    for (int n = 0; n < 40; n++) begin
      if (!busy_o[0] && !busy_o[1] && !busy_o[2]) return;
      tick();
    end
    check("idle_bound", 8'(busy_o[0] | busy_o[1] | busy_o[2]), 8'd0);
  endtask

  task automatic open_round();
    wait_idle();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [4:0] pv;
    for (int k = 0; k < 3; k++) m[k] = '{0, 5'd0, 0, 0, 1'b0, 1'b0, 1'b0};

    // Reset values, then start together with rst stays idle.
    rst = 1'b1;
    tick();
    tick();
    check("reset busy", 8'(busy_o[0]), 8'd0);
    check("reset voted", 8'(voted_o[0]), 8'd0);
    start = 1'b1;
    tick();
    check("rst_over_start busy", 8'(busy_o[0]), 8'd0);
    rst = 1'b0;
    start = 1'b0;
    tick();

    // Single-cycle round.
    open_round();
    check("collect busy", 8'(busy_o[0]), 8'd1);
    vote_valid = 5'b11111;
    vote = 5'b10110;
    tick();
    vote_valid = '0;
    check("single rv", 8'(rv_o[0]), 8'd1);
    check("single result", 8'(result_o[0]), 8'd1);
    check("single ones", 8'(ones_o[0]), 8'd3);
    check("single timeout", 8'(tmo_o[0]), 8'd0);
    check("single quorum", 8'(quorum_o[0]), 8'd1);
    tick();
    check("single rv falls", 8'(rv_o[0]), 8'd0);
    check("single hold ones", 8'(ones_o[0]), 8'd3);

    // Sweep of all vote patterns.
    for (int p = 0; p < 32; p++) begin
      pv = 5'(p);
      open_round();
      vote_valid = 5'b11111;
      vote = pv;
      tick();
      vote_valid = '0;
      check($sformatf("sweep %02h result", p), 8'(result_o[0]), 8'($countones(pv) >= 3));
    end

    // Staggered votes with a duplicate from voter 0.
    open_round();
    vote_valid = 5'b00001; vote = 5'b00001; tick();
    vote_valid = 5'b00001; vote = 5'b00000; tick();
    vote_valid = 5'b00010; vote = 5'b00000; tick();
    vote_valid = 5'b00100; vote = 5'b00000; tick();
    vote_valid = 5'b11000; vote = 5'b01000; tick();
    vote_valid = '0;
    check("stagger rv", 8'(rv_o[0]), 8'd1);
    check("stagger voted", 8'(voted_o[0]), 8'h1f);
    check("stagger ones", 8'(ones_o[0]), 8'd2);
    check("stagger result", 8'(result_o[0]), 8'd0);

    // Timeout on the TIMEOUT=4 instance.
    open_round();
    vote_valid = 5'b00101; vote = 5'b00101; tick();
    vote_valid = '0; vote = '0;
    tick();
    tick();
    check("to4 not yet", 8'(rv_o[1]), 8'd0);
    tick();
    check("to4 rv", 8'(rv_o[1]), 8'd1);
    check("to4 timeout", 8'(tmo_o[1]), 8'd1);
    check("to4 quorum", 8'(quorum_o[1]), 8'd0);
    check("to4 result", 8'(result_o[1]), 8'd0);
    check("to4 voted", 8'(voted_o[1]), 8'h05);

    // Early exit.
    open_round();
    vote_valid = 5'b11010; vote = 5'b11010; tick();
    vote_valid = '0;
    check("early rv", 8'(rv_o[2]), 8'd1);
    check("early result", 8'(result_o[2]), 8'd1);
    check("early timeout", 8'(tmo_o[2]), 8'd0);
    check("early voted", 8'(voted_o[2]), 8'h1a);
    check("noearly busy", 8'(busy_o[0]), 8'd1);

    // Mid-round disturbance: ignored start, then reset.
    open_round();
    vote_valid = 5'b00011; vote = 5'b00001; tick();
    vote_valid = '0;
    start = 1'b1; tick();
    start = 1'b0;
    check("midstart busy", 8'(busy_o[0]), 8'd1);
    check("midstart voted", 8'(voted_o[0]), 8'h03);
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort u%0d voted", k), 8'(voted_o[k]), 8'd0);
      check($sformatf("abort u%0d rv", k), 8'(rv_o[k]), 8'd0);
    end
    tick();
    check("abort no pulse", 8'(rv_o[0]), 8'd0);
    open_round();
    vote_valid = 5'b11111; vote = 5'b11100; tick();
    vote_valid = '0;
    check("clean rv", 8'(rv_o[0]), 8'd1);
    check("clean ones", 8'(ones_o[0]), 8'd3);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 59) == 0);
      start      = ($urandom_range(0, 3) == 0);
      vote_valid = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      vote       = 5'($urandom);
      tick();
    end
    rst = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/majority_vote_sequencer.md
# majority_vote_sequencer

Round-based vote collector and scheduler for the 5-input majority function. It opens a voting window on `start` and accepts at most one vote from each of five voters, each with its own valid strobe. It closes the round when all voters have responded, when an early decision is reached, or on timeout. It then issues a strict-majority decision with a one-cycle `result_valid` pulse. The block sits in front of the combinational 5-bit majority datapath and turns it into a sequenced, handshaked resource.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles spent in COLLECT. Must be ≥1.
- `EARLY_EXIT`, default 0: when 1, the round closes as soon as 3 ones or 3 zeros have been accepted.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  opens a round; honoured only in IDLE.
- `vote_valid`  in  5  per-voter strobe; bit i qualifies `vote[i]`.
- `vote`  in  5  per-voter vote value.
- `busy`  out  1  high in COLLECT and DONE.
- `voted`  out  5  mask of voters accepted in the current or last round.
- `ones_cnt`  out  3  number of accepted votes equal to 1 (range 0..5).
- `result`  out  1  majority decision.
- `result_valid`  out  1  one-cycle pulse in DONE.
- `timeout`  out  1  last round closed by the timer.
- `quorum_ok`  out  1  last round accepted ≥3 votes.

## Operation
States:
- **IDLE**: `busy`=0.
  - `start`=1 → COLLECT.
  - On the same edge: clear `voted`, `ones_cnt`, `result`, `timeout`, `quorum_ok` and the internal timer.
- **COLLECT**: on each edge, for every i with `vote_valid[i]`=1 and `voted[i]`=0:
  - set `voted[i]`;
  - add `vote[i]` to `ones_cnt`.
  - Duplicates from a voter already in `voted` are silently ignored.
  - All five voters may be accepted on the same edge.
- **Close condition**, evaluated on the post-update values of that edge:
  - all five `voted` bits set; or
  - `EARLY_EXIT`=1 and (ones ≥3 or (popcount(`voted`) − ones) ≥3); or
  - timer == `TIMEOUT`−1.
  - Votes presented on the closing edge are still accepted.
- **Closing edge** → DONE. Register:
  - `result` = (ones_cnt ≥ 3); absent voters count as 0;
  - `quorum_ok` = popcount(`voted`) ≥ 3;
  - `timeout` = 1 only if the timer was the sole reason for closing.
- **DONE**: exactly one cycle with `result_valid`=1, then unconditional → IDLE.
- **Ignored inputs**:
  - `start` in COLLECT or DONE is ignored, not queued.
  - `vote_valid` outside COLLECT is ignored.
- **Hold behaviour**: `voted`, `ones_cnt`, `result`, `timeout` and `quorum_ok` hold their values after DONE until the next accepted `start`.
- **Timer**:
  - width $clog2(`TIMEOUT`+1);
  - increments on every COLLECT edge that does not close the round;
  - never wraps.

## Timing
- **Reset**:
  - All outputs reset to 0: `busy`, `voted`, `ones_cnt`, `result`, `result_valid`, `timeout`, `quorum_ok`.
  - State returns to IDLE and the timer is cleared.
  - Reset mid-round (in COLLECT or DONE) aborts the round with no `result_valid` pulse.
  - `rst` has priority over `start`.
- **Latency**:
  - `start` sampled on edge k → COLLECT during cycle k+1.
  - All votes presented in that cycle → DONE after edge k+1, with `result_valid` high in cycle k+2.
  - Minimum latency from the start edge to the `result_valid` edge is 2 cycles.
- **Timeout bound**: with no early close, the round closes on the `TIMEOUT`-th COLLECT edge. `result_valid` therefore falls `TIMEOUT`+1 cycles after the start edge.
- **Back-to-back rounds**: `start` may be reasserted in the cycle after DONE, i.e. in IDLE, so a new round can begin every `TIMEOUT`+2 cycles worst case.
- **Output timing**: all outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset values**: assert `rst` for 2 cycles.
  - All outputs must be 0 and `busy`=0.
  - Pulse `start` together with `rst` → still IDLE.
- **Single-cycle round**: `start`; next cycle `vote_valid`=5'b11111, `vote`=5'b10110.
  - `result_valid` pulses 2 cycles after start with `result`=1, `ones_cnt`=3, `timeout`=0, `quorum_ok`=1.
  - Sweep all 32 `vote` patterns: `result` must equal popcount ≥3.
- **Staggered votes with duplicates**:
  - voter0 sends 1, then voter0 sends 0 again (ignored); voters 1..4 send 0,0,1,0 on later cycles.
  - Require `voted`=5'b11111, `ones_cnt`=2, `result`=0.
- **Timeout**: `TIMEOUT`=4; only voters 0 and 2 vote 1.
  - Close on the 4th COLLECT edge with `timeout`=1, `quorum_ok`=0, `result`=0, `voted`=5'b00101.
- **Early exit**: `EARLY_EXIT`=1; voters 1, 3, 4 vote 1 in the same cycle.
  - DONE follows immediately with `result`=1, `timeout`=0, `voted`=5'b11010.
- **Mid-round disturbance**:
  - `start` pulsed during COLLECT is ignored and the round continues.
  - `rst` during COLLECT → IDLE, no `result_valid` pulse, `voted`=0.
  - The next `start` runs a clean round.
